// File: rtl/psum_arb_pkg.sv
// Shared types for the psum buffer arbiter: read-owner encoding, return tag and
// the default hazard window derived from the memory read latency.
package psum_arb_pkg;

    typedef enum logic {
        OWN_ACC = 1'b0,
        OWN_RDO = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } tag_t;

    // An ACC address stays live for its read, the data return and the write-back.
    function automatic int haz_depth(input int mem_delay);
        return mem_delay + 2;
    endfunction

    localparam int DEF_MEM_DELAY = 1;
    localparam int DEF_HAZ_DEPTH = DEF_MEM_DELAY + 2;

endpackage

// File: rtl/psum_arb_haz_tbl.sv
// Hazard table: shift register of recent ACC read addresses with a parallel
// compare against the RDO read address.
module psum_arb_haz_tbl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_vld,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [ADDR_WIDTH-1:0] chk_addr,
    output logic                  hazard
);

    logic [DEPTH-1:0]      vld;
    logic [ADDR_WIDTH-1:0] addr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= push_vld;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // NOTE: only the valid bits need reset; addresses are ignored while their valid bit is low.
    always_ff @(posedge clk) begin
        addr[0] <= push_addr;
        for (int i = 1; i < DEPTH; i++) begin
            addr[i] <= addr[i-1];
        end
    end

    // NOTE: blocking assignments here build an OR-reduction in loop order.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (addr[i] == chk_addr)) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/psum_mem_arbiter.sv
// Shares the psum buffer read port between ACC (absolute priority) and RDO.
// Optional perf counters are enabled with the macro PSUM_ARB_PERF_CNT_EN.
module psum_mem_arbiter
    import psum_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int MEM_DELAY  = DEF_MEM_DELAY,
    parameter int HAZ_DEPTH  = haz_depth(MEM_DELAY),
    parameter int STALL_MAX  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] acc_radd,
    input  logic                  acc_rden,
    input  logic [ADDR_WIDTH-1:0] acc_wadd,
    input  logic                  acc_wren,
    input  logic [DATA_WIDTH-1:0] acc_idat,
    output logic [DATA_WIDTH-1:0] acc_odat,
    output logic                  acc_ovld,
    input  logic [ADDR_WIDTH-1:0] rdo_radd,
    input  logic                  rdo_req,
    output logic                  rdo_gnt,
    output logic [DATA_WIDTH-1:0] rdo_odat,
    output logic                  rdo_ovld,
    output logic [ADDR_WIDTH-1:0] mem_radd,
    output logic                  mem_rden,
    output logic [ADDR_WIDTH-1:0] mem_wadd,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_idat,
    input  logic [DATA_WIDTH-1:0] mem_odat,
    input  logic                  mem_ovld,
    output logic                  o_rdo_stall,
    output logic                  o_err,
    output logic [REG_WIDTH-1:0]  dbg_arb_acc_rd_cnt,
    output logic [REG_WIDTH-1:0]  dbg_arb_rdo_rd_cnt,
    output logic [REG_WIDTH-1:0]  dbg_arb_rdo_wait_cnt
);

    localparam int                STALL_W   = $clog2(STALL_MAX + 1);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

    logic               hazard;
    logic               rdo_wait;
    tag_t               tag_pipe [MEM_DELAY];
    tag_t               tail;
    logic [STALL_W-1:0] stall_cnt;

    assign mem_wadd = acc_wadd;
    assign mem_wren = acc_wren;
    assign mem_idat = acc_idat;

    psum_arb_haz_tbl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (HAZ_DEPTH)
    ) u_haz_tbl (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (acc_rden),
        .push_addr (acc_radd),
        .chk_addr  (rdo_radd),
        .hazard    (hazard)
    );

    // NOTE: every output gets a default before the branches, so no latch can be inferred.
    always_comb begin
        mem_radd = acc_radd;
        mem_rden = 1'b0;
        rdo_gnt  = 1'b0;
        if (acc_rden) begin
            mem_rden = 1'b1;
        end else if (rdo_req && !hazard) begin
            mem_radd = rdo_radd;
            mem_rden = 1'b1;
            rdo_gnt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DELAY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{vld: mem_rden, owner: (rdo_gnt ? OWN_RDO : OWN_ACC)};
            for (int i = 1; i < MEM_DELAY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tail     = tag_pipe[MEM_DELAY-1];
    assign acc_odat = mem_odat;
    assign rdo_odat = mem_odat;
    assign acc_ovld = mem_ovld & tail.vld & (tail.owner == OWN_ACC);
    assign rdo_ovld = mem_ovld & tail.vld & (tail.owner == OWN_RDO);

    // A return with no tag means memctrl and this block disagree about what is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if (mem_ovld && !tail.vld) begin
            o_err <= 1'b1;
        end
    end

    assign rdo_wait = rdo_req & ~rdo_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt   <= '0;
            o_rdo_stall <= 1'b0;
        end else if (rdo_wait) begin
            if (stall_cnt != STALL_LIM) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (stall_cnt >= STALL_LIM - 1'b1) begin
                o_rdo_stall <= 1'b1;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

`ifdef PSUM_ARB_PERF_CNT_EN
    logic [REG_WIDTH-1:0] acc_rd_cnt;
    logic [REG_WIDTH-1:0] rdo_rd_cnt;
    logic [REG_WIDTH-1:0] rdo_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_rd_cnt   <= '0;
            rdo_rd_cnt   <= '0;
            rdo_wait_cnt <= '0;
        end else begin
            if (acc_rden) acc_rd_cnt   <= acc_rd_cnt + 1'b1;
            if (rdo_gnt)  rdo_rd_cnt   <= rdo_rd_cnt + 1'b1;
            if (rdo_wait) rdo_wait_cnt <= rdo_wait_cnt + 1'b1;
        end
    end

    assign dbg_arb_acc_rd_cnt   = acc_rd_cnt;
    assign dbg_arb_rdo_rd_cnt   = rdo_rd_cnt;
    assign dbg_arb_rdo_wait_cnt = rdo_wait_cnt;
`else
    assign dbg_arb_acc_rd_cnt   = '0;
    assign dbg_arb_rdo_rd_cnt   = '0;
    assign dbg_arb_rdo_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Self-checking bench for psum_mem_arbiter: directed steps plus random traffic
// checked against a cycle-indexed reference model and a shadow memory.
module tb_psum_mem_arbiter;

    localparam int MD   = 1;
    localparam int HD   = MD + 2;
    localparam int SMAX = 256;

    logic        clk;
    logic        rst;
    logic [31:0] acc_radd, acc_wadd, acc_idat, rdo_radd;
    logic        acc_rden, acc_wren, rdo_req;
    logic [31:0] acc_odat, rdo_odat, mem_radd, mem_wadd, mem_idat, mem_odat;
    logic        acc_ovld, rdo_gnt, rdo_ovld, mem_rden, mem_wren, mem_ovld;
    logic        o_rdo_stall, o_err;
    logic [31:0] dbg_arb_acc_rd_cnt, dbg_arb_rdo_rd_cnt, dbg_arb_rdo_wait_cnt;

    logic        inj_ovld;
    logic [31:0] inj_dat;

    psum_mem_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .REG_WIDTH  (32),
        .MEM_DELAY  (MD),
        .HAZ_DEPTH  (HD),
        .STALL_MAX  (SMAX)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .acc_radd             (acc_radd),
        .acc_rden             (acc_rden),
        .acc_wadd             (acc_wadd),
        .acc_wren             (acc_wren),
        .acc_idat             (acc_idat),
        .acc_odat             (acc_odat),
        .acc_ovld             (acc_ovld),
        .rdo_radd             (rdo_radd),
        .rdo_req              (rdo_req),
        .rdo_gnt              (rdo_gnt),
        .rdo_odat             (rdo_odat),
        .rdo_ovld             (rdo_ovld),
        .mem_radd             (mem_radd),
        .mem_rden             (mem_rden),
        .mem_wadd             (mem_wadd),
        .mem_wren             (mem_wren),
        .mem_idat             (mem_idat),
        .mem_odat             (mem_odat),
        .mem_ovld             (mem_ovld),
        .o_rdo_stall          (o_rdo_stall),
        .o_err                (o_err),
        .dbg_arb_acc_rd_cnt   (dbg_arb_acc_rd_cnt),
        .dbg_arb_rdo_rd_cnt   (dbg_arb_rdo_rd_cnt),
        .dbg_arb_rdo_wait_cnt (dbg_arb_rdo_wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int idx);
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    // Memory responder: fixed-latency read, reset together with the arbiter.
    logic [31:0]   mem_arr [256];
    logic [MD-1:0] ret_vld;
    logic [31:0]   ret_dat [MD];

    always @(posedge clk) begin
        if (rst) begin
            ret_vld <= '0;
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
        end else begin
            ret_vld[0] <= mem_rden;
            ret_dat[0] <= mem_arr[mem_radd[7:0]];
            for (int i = 1; i < MD; i++) begin
                ret_vld[i] <= ret_vld[i-1];
                ret_dat[i] <= ret_dat[i-1];
            end
            if (mem_wren) mem_arr[mem_wadd[7:0]] <= mem_idat;
        end
    end

    assign mem_ovld = ret_vld[MD-1] | inj_ovld;
    assign mem_odat = inj_ovld ? inj_dat : ret_dat[MD-1];

    // Reference model state
    typedef struct {
        int          due;
        bit          owner;
        logic [31:0] data;
    } ret_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
    } rd_t;

    ret_t        ret_q [$];
    rd_t         acc_hist [$];
    logic [31:0] golden [256];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          wait_run, n_acc, n_gnt, n_wait;
    bit          exp_stall, exp_err, last_gnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        acc_rden = 1'b0;
        acc_wren = 1'b0;
        rdo_req  = 1'b0;
        inj_ovld = 1'b0;
    endtask

    task automatic check_dbg();
`ifdef PSUM_ARB_PERF_CNT_EN
        check("dbg_acc_rd",   dbg_arb_acc_rd_cnt,   32'(n_acc));
        check("dbg_rdo_rd",   dbg_arb_rdo_rd_cnt,   32'(n_gnt));
        check("dbg_rdo_wait", dbg_arb_rdo_wait_cnt, 32'(n_wait));
`else
        check("dbg_acc_rd",   dbg_arb_acc_rd_cnt,   32'd0);
        check("dbg_rdo_rd",   dbg_arb_rdo_rd_cnt,   32'd0);
        check("dbg_rdo_wait", dbg_arb_rdo_wait_cnt, 32'd0);
`endif
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model.
    task automatic tick();
        bit   haz, gnt, due;
        ret_t r;
        rd_t  h;
        @(negedge clk);
        haz = 1'b0;
        foreach (acc_hist[i]) begin
            if ((cyc - acc_hist[i].cyc) <= HD && acc_hist[i].addr == rdo_radd) haz = 1'b1;
        end
        gnt = !acc_rden && rdo_req && !haz;
        due = (ret_q.size() > 0) && (ret_q[0].due == cyc);

        check("mem_wren", 32'(mem_wren), 32'(acc_wren));
        check("mem_wadd", mem_wadd, acc_wadd);
        check("mem_idat", mem_idat, acc_idat);
        check("rdo_gnt", 32'(rdo_gnt), 32'(gnt));
        check("mem_rden", 32'(mem_rden), 32'(acc_rden | gnt));
        check("mem_radd", mem_radd, gnt ? rdo_radd : acc_radd);
        check("acc_ovld", 32'(acc_ovld), 32'(due && !ret_q[0].owner));
        check("rdo_ovld", 32'(rdo_ovld), 32'(due && ret_q[0].owner));
        if (due) begin
            check("acc_odat", acc_odat, ret_q[0].data);
            check("rdo_odat", rdo_odat, ret_q[0].data);
        end
        check("o_rdo_stall", 32'(o_rdo_stall), 32'(exp_stall));
        check("o_err", 32'(o_err), 32'(exp_err));

        if (due) void'(ret_q.pop_front());
        if (inj_ovld && !due) exp_err = 1'b1;
        if (acc_rden || gnt) begin
            r.due   = cyc + MD;
            r.owner = gnt;
            r.data  = gnt ? golden[rdo_radd[7:0]] : golden[acc_radd[7:0]];
            ret_q.push_back(r);
        end
        if (acc_rden) begin
            h.cyc  = cyc;
            h.addr = acc_radd;
            acc_hist.push_back(h);
            n_acc++;
        end
        if (gnt) n_gnt++;
        if (rdo_req && !gnt) begin
            n_wait++;
            wait_run++;
            if (wait_run >= SMAX) exp_stall = 1'b1;
        end else begin
            wait_run = 0;
        end
        if (acc_wren) golden[acc_wadd[7:0]] = acc_idat;
        last_gnt = gnt;
        cyc++;
        while (acc_hist.size() > 0 && (cyc - acc_hist[0].cyc) > HD) void'(acc_hist.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        ret_q.delete();
        acc_hist.delete();
        exp_stall = 1'b0;
        exp_err   = 1'b0;
        last_gnt  = 1'b0;
        wait_run  = 0;
        n_acc     = 0;
        n_gnt     = 0;
        n_wait    = 0;
        for (int i = 0; i < 256; i++) golden[i] = init_word(i);
        @(negedge clk);
        check("rst_rdo_gnt", 32'(rdo_gnt), 32'd0);
        check("rst_acc_ovld", 32'(acc_ovld), 32'd0);
        check("rst_rdo_ovld", 32'(rdo_ovld), 32'd0);
        check("rst_stall", 32'(o_rdo_stall), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check_dbg();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst      = 1'b1;
        acc_radd = '0;
        acc_wadd = '0;
        acc_idat = '0;
        rdo_radd = '0;
        inj_dat  = '0;
        set_idle();
        do_reset();

        // ACC-only read at 0x10
        acc_rden = 1'b1;
        acc_radd = 32'h10;
        tick();
        set_idle();
        repeat (2) tick();

        // RDO read in an idle gap
        rdo_req  = 1'b1;
        rdo_radd = 32'h40;
        tick();
        rdo_req = 1'b0;
        repeat (2) tick();

        // Same-cycle conflict: ACC wins, RDO granted next cycle
        acc_rden = 1'b1;
        acc_radd = 32'h05;
        rdo_req  = 1'b1;
        rdo_radd = 32'h40;
        tick();
        acc_rden = 1'b0;
        tick();
        rdo_req = 1'b0;
        repeat (2) tick();

        // Hazard: RDO blocked for HAZ_DEPTH cycles behind an ACC read of the same address
        acc_rden = 1'b1;
        acc_radd = 32'h20;
        tick();
        acc_rden = 1'b0;
        rdo_req  = 1'b1;
        rdo_radd = 32'h20;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_gnt && n < 10);
        check("haz_grant_cycle", 32'(n), 32'(HD + 1));
        rdo_req = 1'b0;
        repeat (2) tick();

        // Write then read back through the ACC path
        acc_wren = 1'b1;
        acc_wadd = 32'h33;
        acc_idat = 32'hDEAD_BEEF;
        tick();
        acc_wren = 1'b0;
        acc_rden = 1'b1;
        acc_radd = 32'h33;
        tick();
        set_idle();
        repeat (2) tick();
        check_dbg();

        // Random traffic on a small address set to provoke hazards
        for (int i = 0; i < 500; i++) begin
            acc_rden = 1'($urandom_range(0, 1));
            acc_radd = 32'($urandom_range(0, 15));
            acc_wren = ($urandom_range(0, 3) == 0);
            acc_wadd = 32'($urandom_range(0, 15));
            acc_idat = $urandom;
            if (!rdo_req || last_gnt) begin
                rdo_req  = 1'($urandom_range(0, 1));
                rdo_radd = 32'($urandom_range(0, 15));
            end
            tick();
        end
        set_idle();
        repeat (3) tick();
        check_dbg();

        // Stall: ACC hogs the read port while RDO waits
        tick();
        acc_rden = 1'b1;
        rdo_req  = 1'b1;
        rdo_radd = 32'h41;
        for (int i = 0; i < SMAX - 1; i++) begin
            acc_radd = 32'($urandom_range(0, 15));
            tick();
        end
        check("stall_before_limit", 32'(o_rdo_stall), 32'd0);
        tick();
        check("stall_at_limit", 32'(o_rdo_stall), 32'd1);
        set_idle();
        repeat (4) tick();
        check("stall_sticky", 32'(o_rdo_stall), 32'd1);
        check_dbg();

        // Spurious memory return with nothing outstanding
        inj_ovld = 1'b1;
        inj_dat  = 32'h1234_5678;
        tick();
        inj_ovld = 1'b0;
        tick();
        check("err_sticky", 32'(o_err), 32'd1);

        // Reset clears sticky flags; then 5 ACC reads and 2 RDO grants
        do_reset();
        for (int i = 0; i < 5; i++) begin
            acc_rden = 1'b1;
            acc_radd = 32'(8'h60 + i);
            tick();
        end
        acc_rden = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rdo_req  = 1'b1;
            rdo_radd = 32'(8'h50 + i);
            tick();
        end
        set_idle();
        repeat (2) tick();
        check_dbg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_mem_arbiter.md
Name: psum_mem_arbiter

Overview:
- Shares the single partial-sum accumulator buffer (one read port, one write port, fixed read latency) between two requesters:
  - the accumulator read-modify-write controller (ACC), which has absolute priority and is never stalled;
  - the output readout engine (RDO), which drains finished output sums to the output DMA.
- Sits between the accumulator controller and the psum BRAM memctrl.
- Routes read returns to the correct owner and blocks RDO reads that would hit an address with an ACC update in flight.

Parameters:
DATA_WIDTH, 32, memory word width (4 packed 8-bit kernel sums)
ADDR_WIDTH, 32, memory address width
REG_WIDTH, 32, status/debug register width
MEM_DELAY, 1, memory read latency in cycles (rden to ovld), >=1
HAZ_DEPTH, 3, cycles an ACC read address stays "in flight" (MEM_DELAY+2: read, return, write-back)
STALL_MAX, 256, RDO wait cycles before the stall flag sets

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
acc_radd  in  ADDR_WIDTH  ACC read address
acc_rden  in  1  ACC read strobe (no backpressure)
acc_wadd  in  ADDR_WIDTH  ACC write address
acc_wren  in  1  ACC write strobe
acc_idat  in  DATA_WIDTH  ACC write data
acc_odat  out  DATA_WIDTH  read data to ACC
acc_ovld  out  1  read data valid to ACC
rdo_radd  in  ADDR_WIDTH  RDO read address
rdo_req  in  1  RDO read request, held until granted
rdo_gnt  out  1  RDO read accepted this cycle
rdo_odat  out  DATA_WIDTH  read data to RDO
rdo_ovld  out  1  read data valid to RDO
mem_radd  out  ADDR_WIDTH  memory read address
mem_rden  out  1  memory read enable
mem_wadd  out  ADDR_WIDTH  memory write address
mem_wren  out  1  memory write enable
mem_idat  out  DATA_WIDTH  memory write data
mem_odat  in  DATA_WIDTH  memory read data
mem_ovld  in  1  memory read valid
o_rdo_stall  out  1  sticky: RDO waited STALL_MAX consecutive cycles
o_err  out  1  sticky: mem_ovld with no outstanding tag
dbg_arb_acc_rd_cnt  out  REG_WIDTH  perf counter (macro only, else 0)
dbg_arb_rdo_rd_cnt  out  REG_WIDTH  perf counter (macro only, else 0)
dbg_arb_rdo_wait_cnt  out  REG_WIDTH  perf counter (macro only, else 0)

Behaviour:
- Reset values: rdo_gnt, rdo_ovld, acc_ovld, o_rdo_stall, o_err and all dbg counters are 0. The tag pipe and hazard table are cleared.
- Write port:
  - Owned exclusively by ACC, combinational pass-through.
  - mem_wadd=acc_wadd, mem_wren=acc_wren, mem_idat=acc_idat.
- Read port arbitration (combinational, same cycle):
  - acc_rden=1: mem_radd=acc_radd, mem_rden=1, rdo_gnt=0.
  - acc_rden=0 and rdo_req=1 and no hazard: mem_radd=rdo_radd, mem_rden=1, rdo_gnt=1.
  - Otherwise mem_rden=0. mem_radd holds acc_radd.
- Hazard:
  - A HAZ_DEPTH-entry shift register holds {vld, addr} of every ACC read issued.
  - It shifts every cycle; the new entry is acc_rden/acc_radd.
  - Hazard = rdo_radd equals any valid entry.
  - A hazard-blocked request keeps rdo_gnt=0. RDO holds its request until the entry ages out.
- Return routing:
  - A MEM_DELAY-deep tag pipe carries {vld, owner} per issued read.
  - At mem_ovld, the tail tag selects the owner.
  - acc_odat=rdo_odat=mem_odat, passed through with zero added latency.
  - acc_ovld = mem_ovld & tail.vld & owner==ACC.
  - rdo_ovld = mem_ovld & tail.vld & owner==RDO.
  - mem_ovld with tail.vld=0: both ovld outputs stay 0 and o_err sets.
- Stall counter:
  - Counts cycles with rdo_req=1 and rdo_gnt=0. It clears on grant or when rdo_req drops.
  - When it reaches STALL_MAX, o_rdo_stall sets and stays set until rst.
  - The counter saturates and does not wrap.
- Simultaneous ACC read and RDO request: ACC always wins. RDO loses only that cycle; no starvation escape (by design, ACC cannot stall).
- Reset mid-operation: in-flight tags are dropped, and returns arriving after reset flag o_err. Memctrl must be reset together with this block.

Optional Feature:
- Macro PSUM_ARB_PERF_CNT_EN.
- Defined:
  - dbg_arb_acc_rd_cnt increments per ACC read issued.
  - dbg_arb_rdo_rd_cnt increments per rdo_gnt.
  - dbg_arb_rdo_wait_cnt increments per cycle with rdo_req & ~rdo_gnt.
  - All three are REG_WIDTH wrap-around counters, cleared by rst.
- Undefined: the three dbg ports are tied to 0 and no counter registers exist.

Decomposition:
- Shared package psum_arb_pkg: owner encoding (OWN_ACC=1'b0, OWN_RDO=1'b1), tag struct {vld, owner}, default HAZ_DEPTH expression.
- One natural sub-module: psum_arb_haz_tbl, the parameterised address shift register plus parallel compare that outputs the hazard bit.

Test Plan:
- ACC-only, MEM_DELAY=1: acc_rden pulse at addr 0x10 -> mem_rden=1 and mem_radd=0x10 that cycle; acc_ovld=1 one cycle later with data; rdo_ovld stays 0.
- RDO in idle gap: rdo_req=1 at addr 0x40 with ACC silent -> rdo_gnt=1 that cycle; rdo_ovld=1 one cycle later; acc_ovld stays 0.
- Conflict: acc_rden=1 (0x05) and rdo_req=1 (0x40) in the same cycle -> ACC issued, rdo_gnt=0; next cycle with ACC idle -> rdo_gnt=1.
- Hazard: ACC reads 0x20, then rdo_req at 0x20 in the following idle cycles -> rdo_gnt stays 0 for HAZ_DEPTH=3 cycles, then grants.
- Stall: acc_rden held high 256 cycles while rdo_req=1, STALL_MAX=256 -> o_rdo_stall sets at cycle 256 and stays set after both requests drop.
- Error and macro: inject mem_ovld with no read issued -> o_err=1, no ovld output. With PSUM_ARB_PERF_CNT_EN, 5 ACC reads plus 2 RDO grants -> counters read 5 and 2.
